// File: rtl/fifo_arbiter.sv
// Two-writer / one-reader FIFO access arbiter: tracks occupancy and issues registered grants and strobes.
// Optional macro FIFO_ARB_RR_EN selects round-robin writer arbitration; default build uses fixed priority (writer 0 wins).
module fifo_arbiter #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req0,
  input  logic             wr_req1,
  input  logic [DW-1:0]    wr_data0,
  input  logic [DW-1:0]    wr_data1,
  input  logic             rd_req,
  output logic             wr_gnt0,
  output logic             wr_gnt1,
  output logic             rd_gnt,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic [DW-1:0]    fifo_wr_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] data_count,
  output logic             wr_err,
  output logic             rd_err,
  output logic [2:0]       op_state
);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    NO_OP    = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    WR_ERROR = 3'd4,
    RD_ERROR = 3'd5,
    WR_RD    = 3'd6,
    ILLEGAL  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             gnt0_d, gnt1_d, rd_gnt_d, wr_err_d, rd_err_d;
  logic [DW-1:0]    wr_data_d;
  logic             sel1;
  logic             wr_any, wr_ok, rd_ok;

  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign data_count = count_q;
  assign op_state   = state_q;
  assign fifo_wr_en = wr_gnt0 | wr_gnt1;
  assign fifo_rd_en = rd_gnt;

`ifdef FIFO_ARB_RR_EN
  // rr_ptr_q names the writer that wins the next contention.
  logic rr_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else if (gnt0_d | gnt1_d) begin
      rr_ptr_q <= gnt0_d;
    end
  end

  assign sel1 = wr_req1 & (~wr_req0 | rr_ptr_q);
`else
  assign sel1 = wr_req1 & ~wr_req0;
`endif

  assign wr_any = wr_req0 | wr_req1;
  assign wr_ok  = wr_any & ~full;
  assign rd_ok  = rd_req & ~empty;

  // NOTE: every always_comb output gets a default first so no path leaves a value unassigned (no latch).
  always_comb begin
    state_d   = NO_OP;
    count_d   = count_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rd_gnt_d  = 1'b0;
    wr_err_d  = 1'b0;
    rd_err_d  = 1'b0;
    wr_data_d = '0;

    if (state_q == ILLEGAL) begin
      state_d = INIT;
    end else begin
      if (wr_ok) begin
        gnt0_d    = ~sel1;
        gnt1_d    = sel1;
        wr_data_d = sel1 ? wr_data1 : wr_data0;
      end
      rd_gnt_d = rd_ok;
      wr_err_d = wr_any & full;
      rd_err_d = rd_req & empty;

      unique case ({wr_ok, rd_ok})
        2'b11: state_d = WR_RD;
        2'b10: begin
          state_d = WRITE;
          count_d = count_q + ONE_C;
        end
        2'b01: begin
          state_d = READ;
          count_d = count_q - ONE_C;
        end
        default: begin
          if (wr_any)      state_d = WR_ERROR;
          else if (rd_req) state_d = RD_ERROR;
          else             state_d = NO_OP;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= INIT;
      count_q      <= '0;
      wr_gnt0      <= 1'b0;
      wr_gnt1      <= 1'b0;
      rd_gnt       <= 1'b0;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      wr_gnt0      <= gnt0_d;
      wr_gnt1      <= gnt1_d;
      rd_gnt       <= rd_gnt_d;
      wr_err       <= wr_err_d;
      rd_err       <= rd_err_d;
      fifo_wr_data <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Self-checking bench for fifo_arbiter: directed scenarios plus randomized traffic against an occupancy model.
module tb_fifo_arbiter;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int DW    = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_req0, wr_req1, rd_req;
  logic [DW-1:0]    wr_data0, wr_data1;
  logic             wr_gnt0, wr_gnt1, rd_gnt, fifo_wr_en, fifo_rd_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             full, empty, wr_err, rd_err;
  logic [CNT_W-1:0] data_count;
  logic [2:0]       op_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy and the writer that wins the next tie.
  int m_count = 0;
  bit m_prefer1 = 1'b0;

  fifo_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_req0(wr_req0), .wr_req1(wr_req1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .rd_req(rd_req),
    .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1), .rd_gnt(rd_gnt),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_wr_data(fifo_wr_data),
    .full(full), .empty(empty), .data_count(data_count),
    .wr_err(wr_err), .rd_err(rd_err), .op_state(op_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, then compare every output with the model's prediction.
  task automatic cycle(input bit rst, input bit w0, input bit w1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input bit rd);
    bit rr, pick1, do_wr, do_rd;
    int e_state;
    bit e_g0, e_g1, e_rd, e_we, e_re;
    logic [DW-1:0] e_data;
`ifdef FIFO_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    @(negedge clk);
    reset = rst; wr_req0 = w0; wr_req1 = w1; wr_data0 = d0; wr_data1 = d1; rd_req = rd;
    @(posedge clk);
    #1;
    e_g0 = 0; e_g1 = 0; e_rd = 0; e_we = 0; e_re = 0; e_data = '0;
    if (rst) begin
      m_count = 0;
      m_prefer1 = 0;
      e_state = 0;
    end else begin
      pick1 = w1 && (!w0 || (rr && m_prefer1));
      do_wr = (w0 || w1) && m_count < DEPTH;
      do_rd = rd && m_count > 0;
      e_we  = (w0 || w1) && m_count == DEPTH;
      e_re  = rd && m_count == 0;
      if (do_wr) begin
        e_g1 = pick1;
        e_g0 = !pick1;
        e_data = pick1 ? d1 : d0;
        m_count++;
        if (rr) m_prefer1 = !pick1;
      end
      if (do_rd) begin
        e_rd = 1;
        m_count--;
      end
      if (do_wr && do_rd)  e_state = 6;
      else if (do_wr)      e_state = 2;
      else if (do_rd)      e_state = 3;
      else if (w0 || w1)   e_state = 4;
      else if (rd)         e_state = 5;
      else                 e_state = 1;
    end
    check("op_state",     op_state,     e_state);
    check("data_count",   data_count,   m_count);
    check("full",         full,         m_count == DEPTH);
    check("empty",        empty,        m_count == 0);
    check("wr_gnt0",      wr_gnt0,      e_g0);
    check("wr_gnt1",      wr_gnt1,      e_g1);
    check("fifo_wr_en",   fifo_wr_en,   e_g0 | e_g1);
    check("fifo_wr_data", fifo_wr_data, e_data);
    check("rd_gnt",       rd_gnt,       e_rd);
    check("fifo_rd_en",   fifo_rd_en,   e_rd);
    check("wr_err",       wr_err,       e_we);
    check("rd_err",       rd_err,       e_re);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, '0, '0, 0);
    cycle(1, 0, 0, '0, '0, 0);
  endtask

  initial begin
    logic [3:0] rr_exp;
    logic [3:0] rr_got;
    bit w0, w1, rd;
    int wp, rp;

    reset = 1; wr_req0 = 0; wr_req1 = 0; rd_req = 0; wr_data0 = '0; wr_data1 = '0;
    do_reset();
    check("rst_state", op_state, 3'd0);
    check("rst_empty", empty, 1'b1);

    // Single write from writer 0.
    cycle(0, 1, 0, 32'hA5A5_A5A5, '0, 0);
    check("w1_gnt0",  wr_gnt0, 1'b1);
    check("w1_data",  fifo_wr_data, 32'hA5A5_A5A5);
    check("w1_count", data_count, 4'd1);
    check("w1_state", op_state, 3'd2);

    // Fill from writer 1, then overflow attempt.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, '0, 32'h100 + i, 0);
    check("fill_count", data_count, 4'd8);
    check("fill_full",  full, 1'b1);
    cycle(0, 0, 1, '0, 32'hDEAD, 0);
    check("ovf_err",   wr_err, 1'b1);
    check("ovf_state", op_state, 3'd4);
    check("ovf_count", data_count, 4'd8);

    // Underflow, then read+write from empty.
    do_reset();
    cycle(0, 0, 0, '0, '0, 1);
    check("unf_err",   rd_err, 1'b1);
    check("unf_state", op_state, 3'd5);
    check("unf_count", data_count, 4'd0);
    cycle(0, 1, 0, 32'h55, '0, 1);
    check("unfw_state", op_state, 3'd2);
    check("unfw_count", data_count, 4'd1);

    // Concurrent read/write mid-range and at full.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, i, '0, 0);
    cycle(0, 1, 0, 32'h77, '0, 1);
    check("wrrd_state", op_state, 3'd6);
    check("wrrd_count", data_count, 4'd3);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, i, '0, 0);
    cycle(0, 1, 0, 32'h88, '0, 1);
    check("fullrd_state", op_state, 3'd3);
    check("fullrd_err",   wr_err, 1'b1);
    check("fullrd_count", data_count, 4'd7);

    // Writer contention for four cycles.
    do_reset();
`ifdef FIFO_ARB_RR_EN
    rr_exp = 4'b0101;
`else
    rr_exp = 4'b1111;
`endif
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, 32'hA0 + i, 32'hB0 + i, 0);
      rr_got[i] = wr_gnt0;
    end
    check("contention_gnt0_seq", rr_got, rr_exp);

    // Reset during a write at count 5.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, i, '0, 0);
    cycle(1, 1, 0, 32'h99, '0, 0);
    check("midrst_count", data_count, 4'd0);
    check("midrst_empty", empty, 1'b1);
    check("midrst_state", op_state, 3'd0);
    check("midrst_gnt",   {wr_gnt0, wr_gnt1, rd_gnt}, 3'b000);

    // Random traffic with phases biased towards filling and draining.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      wp = ((i / 150) % 2 == 0) ? 75 : 30;
      rp = ((i / 150) % 2 == 0) ? 30 : 75;
      w0 = ($urandom_range(99) < wp);
      w1 = ($urandom_range(99) < wp);
      rd = ($urandom_range(99) < rp);
      cycle($urandom_range(99) == 0, w0, w1, $urandom(), $urandom(), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO capacity in entries (power of two).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning occupancy counter width (log2(DEPTH)+1).
REQ-003 The block SHALL have parameter DW, default 32, meaning write data width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 The block SHALL have ports wr_req0 / wr_req1, input, 1 each, meaning write requests from writers 0 and 1.
REQ-007 The block SHALL have ports wr_data0 / wr_data1, input, DW each, meaning write payloads, valid with the matching request.
REQ-008 The block SHALL have port rd_req, input, 1, meaning read request from the single reader.
REQ-009 The block SHALL have ports wr_gnt0 / wr_gnt1 / rd_gnt, output, 1 each, meaning one-cycle grant pulses.
REQ-010 The block SHALL have ports fifo_wr_en / fifo_rd_en, output, 1 each, meaning FIFO write and read strobes.
REQ-011 The block SHALL have port fifo_wr_data, output, DW, meaning payload of the granted writer.
REQ-012 The block SHALL have ports full / empty, output, 1 each, meaning data_count==DEPTH and data_count==0.
REQ-013 The block SHALL have port data_count, output, CNT_W, meaning current occupancy, 0..DEPTH.
REQ-014 The block SHALL have ports wr_err / rd_err, output, 1 each, meaning one-cycle pulses for rejected write (full) or read (empty).
REQ-015 The block SHALL have port op_state, output, 3, meaning current FSM state encoding.

Function
REQ-016 The FSM SHALL have states INIT=0, NO_OP=1, WRITE=2, READ=3, WR_ERROR=4, RD_ERROR=5, WR_RD=6; code 7 unreachable, recovers to INIT next cycle.
REQ-017 Requests sampled at edge N SHALL produce state, grants, strobes and fifo_wr_data registered at edge N (visible cycle N+1); one-cycle latency, no combinational request-to-grant path.
REQ-018 At most one writer SHALL be granted per cycle; the grant, fifo_wr_en and fifo_wr_data SHALL be asserted together.
REQ-019 Write request with data_count<DEPTH and no read granted: state WRITE, data_count+1.
REQ-020 Read request with data_count>0 and no write granted: state READ, rd_gnt, fifo_rd_en, data_count-1.
REQ-021 Write and read together with 0<data_count<DEPTH: state WR_RD, both granted, data_count unchanged.
REQ-022 Full (data_count==DEPTH) with any write request: write rejected, wr_err pulses; a simultaneous read is granted (count-1) with state READ, else state WR_ERROR.
REQ-023 Empty (data_count==0) with rd_req: read rejected, rd_err pulses; a simultaneous write is granted (count+1) with state WRITE, else state RD_ERROR.
REQ-024 No requests: state NO_OP, all strobes and grants 0, count held.
REQ-025 data_count SHALL never exceed DEPTH nor wrap below 0.
REQ-026 A non-granted writer SHALL keep its request asserted; dropping it withdraws the request with no error.

Reset
REQ-027 While reset is high at a rising edge: state INIT, data_count 0, empty 1, full 0, all grants/strobes/errors 0, fifo_wr_data 0, round-robin pointer favours writer 0.
REQ-028 Reset asserted mid-operation SHALL discard all pending requests; first grant possible on the edge after reset deasserts.

Configuration
REQ-029 With macro FIFO_ARB_RR_EN defined, writer selection SHALL be round-robin: on contention, the writer not granted last wins; the pointer updates only on a granted write.
REQ-030 Without FIFO_ARB_RR_EN, writer 0 SHALL always win contention (fixed priority); no pointer register exists.

Verification
REQ-031 Reset, then wr_req0=1 data 0xA5A5A5A5 for one cycle -> next cycle wr_gnt0=1, fifo_wr_en=1, fifo_wr_data=0xA5A5A5A5, data_count=1, op_state=2.
REQ-032 Eight writes from writer 1, then a ninth -> data_count=8, full=1, ninth cycle wr_err=1, op_state=4, count stays 8.
REQ-033 From empty, rd_req=1 alone -> rd_err=1, op_state=5, data_count=0; with wr_req0 also -> op_state=2, count=1.
REQ-034 Count=3, wr_req0 and rd_req together -> op_state=6, both grants, count stays 3; at count=8 same stimulus -> op_state=3, wr_err=1, count=7.
REQ-035 Both writers requesting for 4 cycles -> with FIFO_ARB_RR_EN grants 0,1,0,1; without it grants 0,0,0,0.
REQ-036 Reset asserted at count=5 during a write -> next cycle count=0, empty=1, op_state=0, no grants.
